// File: rtl/pakout_arb2_if.sv
// Message channel: 4-phase req/ack with a message word held stable while req is high.
// The master drives req/data and the slave returns ack.
interface pakout_arb2_if #(
    parameter int W = 32
);
    logic         req;
    logic         ack;
    logic [W-1:0] data;

    modport master (output req, output data, input ack);
    modport slave  (input req, input data, output ack);
endinterface

// File: rtl/pakout_arb2.sv
// Two-input round-robin arbiter that forwards whole messages, one at a time,
// from rcv0/rcv1 onto the single snd0 channel feeding pakout.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 8
`endif

module pakout_arb2 #(
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int RSZ = `NS_REDUN_SIZE,
    parameter int CSZ = 16
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,
    pakout_arb2_if.slave   rcv0,
    pakout_arb2_if.slave   rcv1,
    pakout_arb2_if.master  snd0,
    output logic [1:0]     o_grant,
    output logic [CSZ-1:0] o_msg_cnt
);
    localparam int MSZ = ASZ + DSZ + RSZ;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] REL  = 2'd2;

    logic [1:0]     state;
    logic           last;
    logic           elig0;
    logic           elig1;
    logic           any;
    logic           win;
    logic [MSZ-1:0] pick;

    // An input stays ineligible until its own ack has dropped.
    assign elig0 = rcv0.req & ~rcv0.ack;
    assign elig1 = rcv1.req & ~rcv1.ack;
    assign any   = elig0 | elig1;
    assign win   = (elig0 & elig1) ? ~last : elig1;
    assign pick  = win ? rcv1.data : rcv0.data;

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            ready     <= 1'b0;
            rcv0.ack  <= 1'b0;
            rcv1.ack  <= 1'b0;
            snd0.req  <= 1'b0;
            snd0.data <= '0;
            o_grant   <= 2'b00;
            o_msg_cnt <= '0;
            last      <= 1'b1;
            state     <= IDLE;
        end else begin
            ready <= 1'b1;
            if (rcv0.ack && !rcv0.req) rcv0.ack <= 1'b0;
            if (rcv1.ack && !rcv1.req) rcv1.ack <= 1'b0;
            if (ready) begin
                case (state)
                    IDLE: begin
                        // A stuck-high snd0 ack blocks new grants.
                        if (any && !snd0.ack) begin
                            snd0.data <= pick;
                            snd0.req  <= 1'b1;
                            if (win) rcv1.ack <= 1'b1;
                            else     rcv0.ack <= 1'b1;
                            o_grant   <= win ? 2'b10 : 2'b01;
                            last      <= win;
                            state     <= SEND;
                        end
                    end
                    SEND: begin
                        if (snd0.ack) begin
                            snd0.req <= 1'b0;
                            state    <= REL;
                        end
                    end
                    REL: begin
                        if (!snd0.ack) begin
                            o_msg_cnt <= o_msg_cnt + CSZ'(1);
                            o_grant   <= 2'b00;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pakout_arb2.sv
// Bench for pakout_arb2: cycle table for single messages, then producer and
// consumer processes with an expected-message queue; a CSZ=2 copy shadows the inputs.
module tb_pakout_arb2;
    localparam int MSZ = 32;

    typedef struct {
        logic           rq0;
        logic           rq1;
        logic [MSZ-1:0] d0;
        logic [MSZ-1:0] d1;
        logic           sack;
        logic           erdy;
        logic           ea0;
        logic           ea1;
        logic           esreq;
        logic [1:0]     egnt;
        logic [MSZ-1:0] edata;
        int             ecnt;
    } vec_t;

    typedef struct {
        logic [1:0]     g;
        logic [MSZ-1:0] d;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        ready2;
    logic [1:0]  o_grant;
    logic [1:0]  grant2;
    logic [15:0] o_msg_cnt;
    logic [1:0]  cnt2;

    int   checks = 0;
    int   errors = 0;
    int   mcnt   = 0;
    exp_t sbq[$];
    vec_t tv[13];

    always #5 i_clk = ~i_clk;

    pakout_arb2_if #(.W(MSZ)) r0 ();
    pakout_arb2_if #(.W(MSZ)) r1 ();
    pakout_arb2_if #(.W(MSZ)) s0 ();
    pakout_arb2_if #(.W(MSZ)) r0b ();
    pakout_arb2_if #(.W(MSZ)) r1b ();
    pakout_arb2_if #(.W(MSZ)) s0b ();

    assign r0b.req  = r0.req;
    assign r0b.data = r0.data;
    assign r1b.req  = r1.req;
    assign r1b.data = r1.data;
    assign s0b.ack  = s0.ack;

    pakout_arb2 #(.ASZ(8), .DSZ(16), .RSZ(8)) dut (
        .i_clk(i_clk), .reset(reset), .ready(ready),
        .rcv0(r0), .rcv1(r1), .snd0(s0),
        .o_grant(o_grant), .o_msg_cnt(o_msg_cnt)
    );

    pakout_arb2 #(.ASZ(8), .DSZ(16), .RSZ(8), .CSZ(2)) dut2 (
        .i_clk(i_clk), .reset(reset), .ready(ready2),
        .rcv0(r0b), .rcv1(r1b), .snd0(s0b),
        .o_grant(grant2), .o_msg_cnt(cnt2)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic rq0, input logic rq1,
        input logic [MSZ-1:0] d0, input logic [MSZ-1:0] d1, input logic sack,
        input logic ea0, input logic ea1, input logic esreq,
        input logic [1:0] egnt, input logic [MSZ-1:0] edata, input int ecnt);
        vec_t v;
        v.rq0 = rq0; v.rq1 = rq1; v.d0 = d0; v.d1 = d1; v.sack = sack;
        v.erdy = 1'b1; v.ea0 = ea0; v.ea1 = ea1; v.esreq = esreq;
        v.egnt = egnt; v.edata = edata; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic produce0(input int n, input logic [MSZ-1:0] base);
        for (int k = 0; k < n; k++) begin
            r0.data = base + MSZ'(k);
            r0.req  = 1'b1;
            for (int t = 0; t < 100 && !r0.ack; t++) tick();
            chk("p0_ack", 32'(r0.ack), 32'(1));
            r0.req = 1'b0;
            for (int t = 0; t < 100 && r0.ack; t++) tick();
            chk("p0_rel", 32'(r0.ack), 32'(0));
        end
    endtask

    task automatic produce1(input int n, input logic [MSZ-1:0] base);
        for (int k = 0; k < n; k++) begin
            r1.data = base + MSZ'(k);
            r1.req  = 1'b1;
            for (int t = 0; t < 100 && !r1.ack; t++) tick();
            chk("p1_ack", 32'(r1.ack), 32'(1));
            r1.req = 1'b0;
            for (int t = 0; t < 100 && r1.ack; t++) tick();
            chk("p1_rel", 32'(r1.ack), 32'(0));
        end
    endtask

    task automatic consume(input int n, input int stall, input bit lat);
        exp_t e;
        int   t;
        for (int k = 0; k < n; k++) begin
            t = 0;
            while (!s0.req && t < 100) begin
                tick();
                t++;
            end
            chk("snd_req", 32'(s0.req), 32'(1));
            if (lat && k > 0) chk("regrant_lat", 32'(t), 32'(1));
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty got none want entry");
            end else begin
                e = sbq.pop_front();
                chk("snd_data", s0.data, e.d);
                chk("grant", 32'(o_grant), 32'(e.g));
            end
            for (int s = 0; s < stall; s++) begin
                tick();
                chk("stall_data", s0.data, e.d);
                chk("stall_req", 32'(s0.req), 32'(1));
                chk("stall_wait", 32'(e.g == 2'b10 ? r0.ack : r1.ack), 32'(0));
            end
            s0.ack = 1'b1;
            tick();
            chk("snd_drop", 32'(s0.req), 32'(0));
            s0.ack = 1'b0;
            tick();
            mcnt++;
            chk("msg_cnt", 32'(o_msg_cnt), 32'(mcnt));
            chk("msg_cnt2", 32'(cnt2), 32'(mcnt % 4));
        end
    endtask

    task automatic push(input logic [1:0] g, input logic [MSZ-1:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        sbq.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [MSZ-1:0] a;
        logic [MSZ-1:0] b;
        logic [MSZ-1:0] c;
        a = 32'hA5A5_0001;
        b = 32'h5A5A_0002;
        c = 32'hC3C3_0003;
        tv[0]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 0, 0);
        tv[1]  = mk(1, 0, a, 0, 0,  1, 0, 1, 2'b01, a, 0);
        tv[2]  = mk(0, 0, a, 0, 0,  0, 0, 1, 2'b01, a, 0);
        tv[3]  = mk(0, 0, a, 0, 1,  0, 0, 0, 2'b01, a, 0);
        tv[4]  = mk(0, 0, a, 0, 0,  0, 0, 0, 2'b00, a, 1);
        tv[5]  = mk(0, 1, a, b, 1,  0, 0, 0, 2'b00, a, 1);
        tv[6]  = mk(0, 1, a, b, 0,  0, 1, 1, 2'b10, b, 1);
        tv[7]  = mk(1, 1, c, b, 1,  0, 1, 0, 2'b10, b, 1);
        tv[8]  = mk(1, 1, c, b, 0,  0, 1, 0, 2'b00, b, 2);
        tv[9]  = mk(1, 1, c, b, 0,  1, 1, 1, 2'b01, c, 2);
        tv[10] = mk(0, 0, c, b, 0,  0, 0, 1, 2'b01, c, 2);
        tv[11] = mk(0, 0, c, b, 1,  0, 0, 0, 2'b01, c, 2);
        tv[12] = mk(0, 0, c, b, 0,  0, 0, 0, 2'b00, c, 3);

        reset   = 1'b0;
        r0.req  = 1'b0;
        r0.data = '0;
        r1.req  = 1'b0;
        r1.data = '0;
        s0.ack  = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(ready), 32'(0));
        chk("rst_ack0", 32'(r0.ack), 32'(0));
        chk("rst_ack1", 32'(r1.ack), 32'(0));
        chk("rst_sreq", 32'(s0.req), 32'(0));
        chk("rst_data", s0.data, 32'(0));
        chk("rst_grant", 32'(o_grant), 32'(0));
        chk("rst_cnt", 32'(o_msg_cnt), 32'(0));
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            r0.req  = tv[i].rq0;
            r1.req  = tv[i].rq1;
            r0.data = tv[i].d0;
            r1.data = tv[i].d1;
            s0.ack  = tv[i].sack;
            tick();
            chk($sformatf("row%0d_ready", i), 32'(ready), 32'(tv[i].erdy));
            chk($sformatf("row%0d_ack0", i), 32'(r0.ack), 32'(tv[i].ea0));
            chk($sformatf("row%0d_ack1", i), 32'(r1.ack), 32'(tv[i].ea1));
            chk($sformatf("row%0d_sreq", i), 32'(s0.req), 32'(tv[i].esreq));
            chk($sformatf("row%0d_grant", i), 32'(o_grant), 32'(tv[i].egnt));
            chk($sformatf("row%0d_data", i), s0.data, tv[i].edata);
            chk($sformatf("row%0d_cnt", i), 32'(o_msg_cnt), 32'(tv[i].ecnt));
            chk($sformatf("row%0d_cnt2", i), 32'(cnt2), 32'(tv[i].ecnt % 4));
        end

        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        mcnt = 0;
        chk("rerst_cnt", 32'(o_msg_cnt), 32'(0));
        push(2'b01, 32'h1000_0000);
        push(2'b10, 32'h2000_0000);
        push(2'b01, 32'h1000_0001);
        push(2'b10, 32'h2000_0001);
        push(2'b01, 32'h1000_0002);
        fork
            produce0(3, 32'h1000_0000);
            produce1(2, 32'h2000_0000);
            consume(5, 0, 1'b0);
        join

        push(2'b10, 32'h3000_0000);
        push(2'b01, 32'h4000_0000);
        fork
            produce1(1, 32'h3000_0000);
            begin
                tick();
                tick();
                produce0(1, 32'h4000_0000);
            end
            consume(2, 10, 1'b1);
        join

        r0.data = 32'hDEAD_0005;
        r0.req  = 1'b1;
        tick();
        chk("pre_rst_sreq", 32'(s0.req), 32'(1));
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(ready), 32'(0));
        chk("mid_rst_sreq", 32'(s0.req), 32'(0));
        chk("mid_rst_ack0", 32'(r0.ack), 32'(0));
        chk("mid_rst_grant", 32'(o_grant), 32'(0));
        chk("mid_rst_cnt", 32'(o_msg_cnt), 32'(0));
        chk("mid_rst_data", s0.data, 32'(0));
        r0.req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        mcnt = 0;
        push(2'b01, 32'hBEEF_0006);
        fork
            produce0(1, 32'hBEEF_0006);
            consume(1, 0, 1'b0);
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
